fifo_input_arbiter: RTL and testbench
=====================================

Name: fifo_input_arbiter

Overview:
- Shares the single input port of the io881 elastic FIFO chain between NREQ requesters, for example UART RX, a parallel port and a host write path.
- Grants are round-robin and burst-locked. A grant lasts until the owner marks the last word or the burst limit is reached, so a multi-byte record is never interleaved with another requester's data.
- Sits directly in front of the first FIFO element and honours that element's full indication.

Parameters:
- WIDTH, 8: data word width.
- NREQ, 4: number of requesters, 2..8.
- MAX_BURST, 4: maximum words per grant, 1..15.
- IDLE_LIMIT, 3: owner-idle cycles before forced release (optional feature only), 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  word currently presented is the last of the record.
- req_ready  out  NREQ  word accepted this cycle (one-hot or zero).
- fifo_full  in  1  first FIFO element full; no write is possible.
- fifo_in_valid  out  1  write strobe to the FIFO input.
- fifo_in_data  out  WIDTH  data to the FIFO input.
- grant_valid  out  1  registered: a requester owns the port.
- grant_id  out  clog2(NREQ)  registered owner index.

Behaviour:
- Reset (asynchronous, applied immediately):
  - state=IDLE, grant_valid=0, grant_id=0, burst count=0, rr pointer=0.
  - fifo_in_valid=0, req_ready=0, fifo_in_data=0.
- Reset mid-burst abandons the burst. No word is written in the reset cycle; after reset the search starts at index 0.
- States and transitions:
  - IDLE: if any req_valid, pick the first asserted index at or after the rr pointer (wrapping modulo NREQ). Register grant_id to the winner, set grant_valid=1, clear the count, go to GRANT. Otherwise stay in IDLE.
  - GRANT, datapath (combinational from owner):
    - fifo_in_valid = req_valid[grant_id] & ~fifo_full.
    - fifo_in_data = req_data[grant_id].
    - req_ready[grant_id] = fifo_in_valid; all other req_ready bits are 0.
  - GRANT, transfer: a transfer is fifo_in_valid=1. On each transfer the count increments.
  - GRANT, release: release when a transfer has req_last=1, or when a transfer brings the count to MAX_BURST.
    - On release: next state IDLE, grant_valid=0, rr pointer = grant_id+1 (wrapping from NREQ-1 to 0).
- Latency:
  - One bubble cycle in IDLE between grants.
  - First word is written no earlier than 1 cycle after req_valid rises.
  - Sustained rate is 1 word/cycle within a grant.
- fifo_full=1 stalls the owner with no state change; the count does not advance.
- Owner req_valid low in GRANT: the grant is held and nothing is written (base build).
- Simultaneous requests are resolved by the rr pointer only; priority is never fixed.
- req_last on a non-transferred cycle (stalled) has no effect.
- MAX_BURST=1: every transfer releases.
- Non-owner data and last inputs are ignored.

Optional Feature:
- Macro: FIFO_ARB_IDLE_RELEASE_EN.
- Defined:
  - A counter counts consecutive GRANT cycles with req_valid[grant_id]=0.
  - On reaching IDLE_LIMIT it forces release exactly like a normal release: IDLE, rr advance, count cleared.
  - Any owner-valid cycle clears the counter.
  - Cycles stalled by fifo_full with owner valid do not count.
- Undefined: no counter exists; the grant is held indefinitely while the owner is idle.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - the clog2 helper function for the grant_id and count widths.
- Sub-module rr_pick (combinational): inputs are the request vector and the pointer; outputs are found and index.
- The arbiter owns all registers.

Test Plan:
1. Single requester, NREQ=4: req 2 presents 0xA1, 0xA2 (last) with fifo_full=0.
   - grant_id=2 one cycle after valid.
   - FIFO receives A1 then A2 on consecutive cycles.
   - grant_valid drops the next cycle.
2. All four request continuously, each with 1-word records.
   - Grants rotate 0, 1, 2, 3, 0.
   - One write every 2 cycles.
3. Burst cap, MAX_BURST=4: req 0 streams 6 words with no last.
   - 4 words are written, then release.
   - req 1 (pending) is granted next.
   - req 0's remaining 2 words follow only on a later grant.
4. Back-pressure: fifo_full=1 for 3 cycles mid-record on owner 1.
   - req_ready=0 and no writes during the stall.
   - Word order and count are preserved.
   - Release happens on the last word.
5. reset_n pulsed low during a burst by owner 3.
   - Outputs are 0 immediately.
   - After release of reset with req 1 and req 3 valid, grant_id=1 (pointer back at 0).
6. With FIFO_ARB_IDLE_RELEASE_EN, IDLE_LIMIT=3: owner 0 drops valid after 1 word, req 2 waiting.
   - Release after 3 idle cycles; req 2 is granted.
   - Without the macro, owner 0 keeps the grant for 20+ cycles.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO input arbiter.
//   state_t : arbiter FSM encoding (ST_IDLE / ST_GRANT)
//   clog2   : width helper for grant index and counters
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bits needed to index v distinct values (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_input_arbiter_rr_pick.sv
// Round-robin picker: finds the first asserted request at or after ptr,
// wrapping modulo NREQ. Purely combinational.
//   req   : request vector
//   ptr   : search start index
//   found : at least one request asserted
//   idx   : winning index (0 when nothing found)
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int sel;
        found = 1'b0;
        idx   = '0;
        sel   = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            sel = (int'(ptr) + (int'(NREQ) - 1 - k)) % int'(NREQ);
            if (req[sel]) begin
                found = 1'b1;
                idx   = ID_W'(sel);
            end
        end
    end

endmodule

// File: rtl/fifo_input_arbiter.sv
// Round-robin, burst-locked arbiter sharing the input of the first elastic
// FIFO element between NREQ requesters. A grant holds until the owner
// transfers a word marked last or MAX_BURST words have been transferred.
// Optional macro FIFO_ARB_IDLE_RELEASE_EN: release the grant after
// IDLE_LIMIT consecutive owner-idle cycles.
// Ports:
//   clk, reset_n     : clock, async active-low reset
//   req_valid/data/last, req_ready : per-requester word interface
//   fifo_full        : first FIFO element cannot accept a word
//   fifo_in_valid/data : write port to the FIFO (combinational from owner)
//   grant_valid, grant_id : registered ownership status
module fifo_input_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned IDLE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_in_valid,
    output logic [WIDTH-1:0]         fifo_in_data,
    output logic                     grant_valid,
    output logic [clog2(NREQ)-1:0]   grant_id
);

    localparam int unsigned ID_W  = clog2(NREQ);
    localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_d;
    logic              grant_valid_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              owner_valid;
    logic              owner_last;
    logic [WIDTH-1:0]  owner_data;

`ifdef FIFO_ARB_IDLE_RELEASE_EN
    localparam int unsigned IDLE_W = clog2(IDLE_LIMIT + 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the current owner's inputs.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ID_W'(i) == grant_id) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
`ifdef FIFO_ARB_IDLE_RELEASE_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef FIFO_ARB_IDLE_RELEASE_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    // Next-state: grant selection, burst counting, release.
    always_comb begin
        logic rel;
        state_d       = state_q;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        burst_cnt_d   = burst_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        rel           = 1'b0;
`ifdef FIFO_ARB_IDLE_RELEASE_EN
        idle_cnt_d    = idle_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FIFO_ARB_IDLE_RELEASE_EN
                idle_cnt_d = '0;
`endif
                if (pick_found) begin
                    state_d       = ST_GRANT;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    burst_cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // Only a completed transfer advances the count or honours last.
                if (fifo_in_valid) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (owner_last || (burst_cnt_d == CNT_W'(MAX_BURST))) begin
                        rel = 1'b1;
                    end
                end
`ifdef FIFO_ARB_IDLE_RELEASE_EN
                // Stalled-but-valid cycles clear the idle count like any valid cycle.
                if (owner_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_d == IDLE_W'(IDLE_LIMIT)) begin
                        rel = 1'b1;
                    end
                end
`endif
                if (rel) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    burst_cnt_d   = '0;
                    rr_ptr_d      = (grant_id == ID_W'(NREQ - 1)) ? '0
                                                                  : grant_id + ID_W'(1);
`ifdef FIFO_ARB_IDLE_RELEASE_EN
                    idle_cnt_d    = '0;
`endif
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // Output datapath: forward the owner's word while the FIFO can take it.
    always_comb begin
        fifo_in_valid = 1'b0;
        fifo_in_data  = '0;
        req_ready     = '0;
        if (state_q == ST_GRANT) begin
            fifo_in_valid = owner_valid & ~fifo_full;
            fifo_in_data  = owner_data;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (ID_W'(i) == grant_id) begin
                    req_ready[i] = fifo_in_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_input_arbiter.sv
// Directed bench for fifo_input_arbiter (WIDTH=8, NREQ=4, MAX_BURST=4,
// IDLE_LIMIT=3). Inputs change 1 time unit after the rising edge; the
// FIFO write log is captured on the falling edge.
module tb_fifo_input_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_in_valid;
    logic [7:0]  fifo_in_data;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int checks;
    int passed;
    logic [7:0] wq[$];

    fifo_input_arbiter #(
        .WIDTH      (8),
        .NREQ       (4),
        .MAX_BURST  (4),
        .IDLE_LIMIT (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_data  (fifo_in_data),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every word written into the FIFO.
    always @(negedge clk) begin
        if (reset_n && fifo_in_valid) wq.push_back(fifo_in_data);
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]      = v;
        req_data[i*8 +: 8] = d;
        req_last[i]       = l;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        wq.delete();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$]);
        checks++;
        if (wq.size() != exp.size()) begin
            $display("FAIL %s_count got %0d exp %0d", name, wq.size(), exp.size());
        end else begin
            int bad;
            bad = 0;
            for (int i = 0; i < exp.size(); i++) begin
                if (wq[i] !== exp[i]) begin
                    if (bad == 0)
                        $display("FAIL %s_word%0d got %h exp %h", name, i, wq[i], exp[i]);
                    bad++;
                end
            end
            if (bad == 0) passed++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'hFFFF_FFFF;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant_valid !== 1'b0) $display("FAIL rst_gv got %b exp 0", grant_valid); else passed++;
        checks++; if (grant_id !== 2'd0) $display("FAIL rst_gid got %0d exp 0", grant_id); else passed++;
        checks++; if (fifo_in_valid !== 1'b0) $display("FAIL rst_fiv got %b exp 0", fifo_in_valid); else passed++;
        checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", req_ready); else passed++;
        checks++; if (fifo_in_data !== 8'h00) $display("FAIL rst_data got %h exp 00", fifo_in_data); else passed++;
        req_valid = '0;
        req_data  = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        exp = '{8'hA1, 8'hA2};
        do_reset();
        set_req(2, 1'b1, 8'hA1, 1'b0);
        #1;
        checks++; if (fifo_in_valid !== 1'b0) $display("FAIL t1_no_early_write got %b exp 0", fifo_in_valid); else passed++;
        tick();
        checks++; if (grant_id !== 2'd2) $display("FAIL t1_gid got %0d exp 2", grant_id); else passed++;
        checks++; if (grant_valid !== 1'b1) $display("FAIL t1_gv got %b exp 1", grant_valid); else passed++;
        checks++; if (fifo_in_data !== 8'hA1) $display("FAIL t1_d0 got %h exp a1", fifo_in_data); else passed++;
        checks++; if (req_ready !== 4'b0100) $display("FAIL t1_ready got %b exp 0100", req_ready); else passed++;
        tick();
        set_req(2, 1'b1, 8'hA2, 1'b1);
        #1;
        checks++; if (fifo_in_valid !== 1'b1 || fifo_in_data !== 8'hA2)
            $display("FAIL t1_d1 got v=%b %h exp v=1 a2", fifo_in_valid, fifo_in_data); else passed++;
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (grant_valid !== 1'b0) $display("FAIL t1_release got %b exp 0", grant_valid); else passed++;
        check_log("t1_log", exp);
    endtask

    task automatic test_rotate();
        logic [7:0] exp[$];
        exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (grant_id !== 2'(k % 4) || fifo_in_valid !== 1'b1)
                $display("FAIL t2_grant%0d got id=%0d v=%b exp id=%0d v=1", k, grant_id, fifo_in_valid, k % 4);
            else passed++;
            tick();
            checks++; if (fifo_in_valid !== 1'b0 || grant_valid !== 1'b0)
                $display("FAIL t2_bubble%0d got v=%b gv=%b exp 0 0", k, fifo_in_valid, grant_valid);
            else passed++;
        end
        req_valid = '0;
        #1;
        check_log("t2_log", exp);
    endtask

    task automatic test_burst_cap();
        logic [7:0] exp[$];
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h34, 8'h35};
        do_reset();
        set_req(0, 1'b1, 8'h30, 1'b0);
        set_req(1, 1'b1, 8'h40, 1'b1);
        tick();
        checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0001)
            $display("FAIL t3_first got id=%0d rdy=%b exp 0 0001", grant_id, req_ready); else passed++;
        for (int w = 1; w < 4; w++) begin
            tick();
            set_req(0, 1'b1, 8'(8'h30 + w), 1'b0);
            #1;
            checks++; if (grant_valid !== 1'b1 || fifo_in_data !== 8'(8'h30 + w))
                $display("FAIL t3_w%0d got gv=%b %h exp 1 %h", w, grant_valid, fifo_in_data, 8'(8'h30 + w));
            else passed++;
        end
        tick();
        set_req(0, 1'b1, 8'h34, 1'b0);
        #1;
        checks++; if (grant_valid !== 1'b0) $display("FAIL t3_cap_release got %b exp 0", grant_valid); else passed++;
        tick();
        checks++; if (grant_id !== 2'd1 || fifo_in_data !== 8'h40)
            $display("FAIL t3_next_owner got id=%0d %h exp 1 40", grant_id, fifo_in_data); else passed++;
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (grant_id !== 2'd0 || fifo_in_data !== 8'h34)
            $display("FAIL t3_regrant got id=%0d %h exp 0 34", grant_id, fifo_in_data); else passed++;
        tick();
        set_req(0, 1'b1, 8'h35, 1'b1);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check_log("t3_log", exp);
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp[$];
        exp = '{8'h50, 8'h51, 8'h52};
        do_reset();
        set_req(1, 1'b1, 8'h50, 1'b0);
        tick();
        checks++; if (grant_id !== 2'd1 || fifo_in_data !== 8'h50)
            $display("FAIL t4_first got id=%0d %h exp 1 50", grant_id, fifo_in_data); else passed++;
        tick();
        set_req(1, 1'b1, 8'h51, 1'b0);
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (fifo_in_valid !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b1)
                $display("FAIL t4_stall%0d got v=%b rdy=%b gv=%b exp 0 0000 1", s, fifo_in_valid, req_ready, grant_valid);
            else passed++;
            tick();
        end
        fifo_full = 1'b0;
        #1;
        checks++; if (fifo_in_valid !== 1'b1 || fifo_in_data !== 8'h51)
            $display("FAIL t4_resume got v=%b %h exp 1 51", fifo_in_valid, fifo_in_data); else passed++;
        tick();
        set_req(1, 1'b1, 8'h52, 1'b1);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        checks++; if (grant_valid !== 1'b0) $display("FAIL t4_release got %b exp 0", grant_valid); else passed++;
        check_log("t4_log", exp);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(3, 1'b1, 8'h60, 1'b0);
        tick();
        checks++; if (grant_id !== 2'd3) $display("FAIL t5_owner got %0d exp 3", grant_id); else passed++;
        tick();
        set_req(3, 1'b1, 8'h61, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || fifo_in_valid !== 1'b0 ||
                      req_ready !== 4'b0000 || fifo_in_data !== 8'h00)
            $display("FAIL t5_async got gv=%b id=%0d v=%b rdy=%b d=%h exp all 0",
                     grant_valid, grant_id, fifo_in_valid, req_ready, fifo_in_data);
        else passed++;
        set_req(1, 1'b1, 8'h70, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1)
            $display("FAIL t5_ptr_reset got id=%0d gv=%b exp 1 1", grant_id, grant_valid); else passed++;
    endtask

    task automatic test_idle_owner();
        do_reset();
        set_req(0, 1'b1, 8'h70, 1'b0);
        set_req(2, 1'b1, 8'h80, 1'b1);
        tick();
        checks++; if (grant_id !== 2'd0) $display("FAIL t6_owner got %0d exp 0", grant_id); else passed++;
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
`ifdef FIFO_ARB_IDLE_RELEASE_EN
        tick();
        tick();
        checks++; if (grant_valid !== 1'b1) $display("FAIL t6_hold2 got %b exp 1", grant_valid); else passed++;
        tick();
        checks++; if (grant_valid !== 1'b0) $display("FAIL t6_idle_release got %b exp 0", grant_valid); else passed++;
        tick();
        checks++; if (grant_id !== 2'd2 || grant_valid !== 1'b1)
            $display("FAIL t6_next got id=%0d gv=%b exp 2 1", grant_id, grant_valid); else passed++;
`else
        for (int c = 0; c < 22; c++) tick();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || fifo_in_valid !== 1'b0)
            $display("FAIL t6_hold got gv=%b id=%0d v=%b exp 1 0 0", grant_valid, grant_id, fifo_in_valid);
        else passed++;
`endif
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_burst_cap();
        test_back_pressure();
        test_reset_mid_burst();
        test_idle_owner();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
